fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the instruction ROM. It owns the program counter and drives the ROM's address and enable. It absorbs the ROM's one-cycle registered read latency and delivers {pc, instruction} pairs to decode over a valid/ready handshake. It supports redirect (branch/jump) with flush and a sticky fault on illegal fetch addresses.

---
 rtl/fetch_unit.sv | 139 +++++++++++++
 tb/tb_fetch_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the ROM read port and hands
// {pc, instruction} pairs to decode through a 2-entry buffer with redirect/flush.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] ADDR_MAX = 32'd1020
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] rom_address,
  output logic        rom_enable,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fault
);

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [1:0]  count_q, count_d;
  logic        inflight_q, inflight_d;
  logic        fault_q, fault_d;
  logic [31:0] head_pc_q, head_pc_d, head_data_q, head_data_d;
  logic [31:0] tail_pc_q, tail_pc_d, tail_data_q, tail_data_d;

  logic       pc_legal, redirect_legal, do_redirect;
  logic       pop, capture, issue, space;
  logic [2:0] occupancy;

  assign pc_legal       = (pc_q[1:0] == 2'b00) && (pc_q <= ADDR_MAX);
  assign redirect_legal = (redirect_pc[1:0] == 2'b00) && (redirect_pc <= ADDR_MAX);
  assign do_redirect    = redirect_valid && (state_q != StBoot);

  assign inst_valid = (count_q != 2'd0) && !redirect_valid;
  assign pop        = inst_valid && inst_ready;
  assign capture    = inflight_q && !redirect_valid;

  // Slots that will be occupied next cycle if nothing new is issued now.
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign space     = occupancy < 3'd2;
  assign issue     = (state_q == StRun) && !redirect_valid && pc_legal && space;

  assign rom_address = pc_q;
  assign rom_enable  = issue;
  assign inst_data   = head_data_q;
  assign inst_pc     = head_pc_q;
  assign fault       = fault_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    count_d     = count_q;
    inflight_d  = inflight_q;
    fault_d     = fault_q;
    head_pc_d   = head_pc_q;
    head_data_d = head_data_q;
    tail_pc_d   = tail_pc_q;
    tail_data_d = tail_data_q;

    if (do_redirect) begin
      count_d    = 2'd0;
      inflight_d = 1'b0;
      pc_d       = redirect_pc;
      if (redirect_legal) begin
        fault_d = 1'b0;
        state_d = StRun;
      end
    end else begin
      case (state_q)
        StBoot: state_d = StRun;
        StRun: begin
          if (space && !pc_legal) begin
            fault_d = 1'b1;
            state_d = StHalt;
          end
        end
        default: ;
      endcase

      inflight_d = issue;
      if (issue) begin
        pc_d     = pc_q + 32'd4;
        req_pc_d = pc_q;
      end

      if (pop) begin
        head_pc_d   = tail_pc_q;
        head_data_d = tail_data_q;
      end

      // The returning word lands at the first free slot after this cycle's pop.
      if (capture) begin
        if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
          head_pc_d   = req_pc_q;
          head_data_d = rom_data;
        end else begin
          tail_pc_d   = req_pc_q;
          tail_data_d = rom_data;
        end
      end

      count_d = count_q + {1'b0, capture} - {1'b0, pop};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StBoot;
      pc_q        <= RESET_PC;
      req_pc_q    <= 32'd0;
      count_q     <= 2'd0;
      inflight_q  <= 1'b0;
      fault_q     <= 1'b0;
      head_pc_q   <= 32'd0;
      head_data_q <= 32'd0;
      tail_pc_q   <= 32'd0;
      tail_data_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      fault_q     <= fault_d;
      head_pc_q   <= head_pc_d;
      head_data_q <= head_data_d;
      tail_pc_q   <= tail_pc_d;
      tail_data_q <= tail_data_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural one-cycle ROM; inputs change
// just after the falling edge and outputs are checked 1 time unit later.
module tb_fetch_unit;

  logic        clock;
  logic        reset_n;
  logic [31:0] rom_address;
  logic        rom_enable;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fault;

  int checks;
  int failures;

  logic [31:0] rom_mem [256];

  fetch_unit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .rom_address    (rom_address),
    .rom_enable     (rom_enable),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .fault          (fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Registered ROM: word appears the cycle after an issue and is held otherwise.
  always @(posedge clock) begin
    if (rom_enable) rom_data <= rom_mem[rom_address[9:2]];
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks         = 0;
    failures       = 0;
    rom_data       = 32'd0;
    for (int i = 0; i < 256; i++) rom_mem[i] = 32'hBAD0_0000 | i;
    rom_mem[0]     = 32'h0000_0000;
    rom_mem[1]     = 32'h9912_7254;
    rom_mem[2]     = 32'h1234_5678;
    rom_mem[3]     = 32'h8911_7843;
    rom_mem[4]     = 32'h1241_8549;
    rom_mem[254]   = 32'hCAFE_F00D;
    rom_mem[255]   = 32'hDEAD_BEEF;
    reset_n        = 1'b0;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;

    // Outputs while held in reset.
    #2;
    chk1("rst_rom_enable", rom_enable, 1'b0);
    chk1("rst_inst_valid", inst_valid, 1'b0);
    chk32("rst_rom_address", rom_address, 32'h0);
    chk32("rst_inst_data", inst_data, 32'h0);
    chk32("rst_inst_pc", inst_pc, 32'h0);
    chk1("rst_fault", fault, 1'b0);

    // Streaming from reset with decode always ready.
    tick(); reset_n = 1'b1; #1;
    chk1("s_c0_rom_enable", rom_enable, 1'b0);
    tick(); #1;
    chk1("s_c1_rom_enable", rom_enable, 1'b1);
    chk32("s_c1_rom_address", rom_address, 32'd0);
    tick(); #1;
    chk1("s_c2_inst_valid", inst_valid, 1'b0);
    chk32("s_c2_rom_address", rom_address, 32'd4);
    tick(); #1;
    chk1("s_c3_inst_valid", inst_valid, 1'b1);
    chk32("s_c3_inst_pc", inst_pc, 32'd0);
    chk32("s_c3_inst_data", inst_data, 32'h0000_0000);
    tick(); #1;
    chk32("s_c4_inst_pc", inst_pc, 32'd4);
    chk32("s_c4_inst_data", inst_data, 32'h9912_7254);
    tick(); #1;
    chk32("s_c5_inst_pc", inst_pc, 32'd8);
    chk32("s_c5_inst_data", inst_data, 32'h1234_5678);
    tick(); #1;
    chk32("s_c6_inst_pc", inst_pc, 32'd12);
    chk32("s_c6_inst_data", inst_data, 32'h8911_7843);
    tick(); #1;
    chk1("s_c7_inst_valid", inst_valid, 1'b1);
    chk32("s_c7_inst_pc", inst_pc, 32'd16);
    chk32("s_c7_inst_data", inst_data, 32'h1241_8549);
    chk1("s_c7_rom_enable", rom_enable, 1'b1);
    chk32("s_c7_rom_address", rom_address, 32'd24);

    // Asynchronous reset between edges while streaming.
    #2; reset_n = 1'b0; inst_ready = 1'b0; #1;
    chk1("ar_inst_valid", inst_valid, 1'b0);
    chk1("ar_rom_enable", rom_enable, 1'b0);
    chk32("ar_rom_address", rom_address, 32'd0);

    // Decode stalled from reset: exactly two issues, then hold.
    tick(); reset_n = 1'b1; #1;
    chk1("st_c0_rom_enable", rom_enable, 1'b0);
    tick(); #1;
    chk1("st_c1_rom_enable", rom_enable, 1'b1);
    chk32("st_c1_rom_address", rom_address, 32'd0);
    tick(); #1;
    chk1("st_c2_rom_enable", rom_enable, 1'b1);
    chk32("st_c2_rom_address", rom_address, 32'd4);
    tick(); #1;
    chk1("st_c3_rom_enable", rom_enable, 1'b0);
    chk1("st_c3_inst_valid", inst_valid, 1'b1);
    tick(); #1;
    chk1("st_c4_rom_enable", rom_enable, 1'b0);
    tick(); #1;
    chk1("st_c5_rom_enable", rom_enable, 1'b0);
    chk32("st_c5_inst_pc", inst_pc, 32'd0);
    chk32("st_c5_inst_data", inst_data, 32'h0000_0000);
    tick(); inst_ready = 1'b1; #1;
    chk1("st_c6_inst_valid", inst_valid, 1'b1);
    chk32("st_c6_inst_pc", inst_pc, 32'd0);
    chk1("st_c6_rom_enable", rom_enable, 1'b1);
    chk32("st_c6_rom_address", rom_address, 32'd8);
    tick(); #1;
    chk32("st_c7_inst_pc", inst_pc, 32'd4);
    chk32("st_c7_inst_data", inst_data, 32'h9912_7254);

    // Redirect to 8 with an entry buffered and a word in flight.
    redirect_valid = 1'b1; redirect_pc = 32'd8; #1;
    chk1("rd_r0_inst_valid", inst_valid, 1'b0);
    chk1("rd_r0_rom_enable", rom_enable, 1'b0);
    tick(); redirect_valid = 1'b0; #1;
    chk1("rd_r1_inst_valid", inst_valid, 1'b0);
    chk1("rd_r1_rom_enable", rom_enable, 1'b1);
    chk32("rd_r1_rom_address", rom_address, 32'd8);
    tick(); #1;
    chk1("rd_r2_inst_valid", inst_valid, 1'b0);
    tick(); #1;
    chk1("rd_r3_inst_valid", inst_valid, 1'b1);
    chk32("rd_r3_inst_pc", inst_pc, 32'd8);
    chk32("rd_r3_inst_data", inst_data, 32'h1234_5678);
    tick(); #1;
    chk32("rd_r4_inst_pc", inst_pc, 32'd12);
    chk32("rd_r4_inst_data", inst_data, 32'h8911_7843);

    // Redirect to a misaligned address: fault, no issues.
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h6; #1;
    chk1("mis_r0_inst_valid", inst_valid, 1'b0);
    tick(); redirect_valid = 1'b0; #1;
    chk1("mis_r1_rom_enable", rom_enable, 1'b0);
    chk1("mis_r1_fault", fault, 1'b0);
    chk1("mis_r1_inst_valid", inst_valid, 1'b0);
    tick(); #1;
    chk1("mis_r2_fault", fault, 1'b1);
    chk1("mis_r2_rom_enable", rom_enable, 1'b0);
    tick(); #1;
    chk1("mis_r3_rom_enable", rom_enable, 1'b0);
    chk1("mis_r3_inst_valid", inst_valid, 1'b0);

    // Legal redirect out of the halted state.
    redirect_valid = 1'b1; redirect_pc = 32'd4; #1;
    chk1("rec_r0_fault", fault, 1'b1);
    tick(); redirect_valid = 1'b0; #1;
    chk1("rec_r1_fault", fault, 1'b0);
    chk1("rec_r1_rom_enable", rom_enable, 1'b1);
    chk32("rec_r1_rom_address", rom_address, 32'd4);
    tick(); #1;
    chk1("rec_r2_inst_valid", inst_valid, 1'b0);
    tick(); #1;
    chk1("rec_r3_inst_valid", inst_valid, 1'b1);
    chk32("rec_r3_inst_pc", inst_pc, 32'd4);
    chk32("rec_r3_inst_data", inst_data, 32'h9912_7254);

    // Run off the end of the ROM.
    tick(); redirect_valid = 1'b1; redirect_pc = 32'd1016; #1;
    tick(); redirect_valid = 1'b0; #1;
    chk1("end_r1_rom_enable", rom_enable, 1'b1);
    chk32("end_r1_rom_address", rom_address, 32'd1016);
    tick(); #1;
    chk32("end_r2_rom_address", rom_address, 32'd1020);
    chk1("end_r2_rom_enable", rom_enable, 1'b1);
    tick(); #1;
    chk1("end_r3_rom_enable", rom_enable, 1'b0);
    chk1("end_r3_fault", fault, 1'b0);
    chk32("end_r3_inst_pc", inst_pc, 32'd1016);
    chk32("end_r3_inst_data", inst_data, 32'hCAFE_F00D);
    tick(); #1;
    chk1("end_r4_fault", fault, 1'b1);
    chk1("end_r4_inst_valid", inst_valid, 1'b1);
    chk32("end_r4_inst_pc", inst_pc, 32'd1020);
    chk32("end_r4_inst_data", inst_data, 32'hDEAD_BEEF);
    chk32("end_r4_rom_address", rom_address, 32'd1024);
    chk1("end_r4_rom_enable", rom_enable, 1'b0);
    tick(); #1;
    chk1("end_r5_inst_valid", inst_valid, 1'b0);
    chk1("end_r5_rom_enable", rom_enable, 1'b0);

    // Reset between edges clears the sticky fault and restarts at RESET_PC.
    #2; reset_n = 1'b0; #1;
    chk1("fr_fault", fault, 1'b0);
    chk32("fr_rom_address", rom_address, 32'd0);
    tick(); reset_n = 1'b1; #1;
    chk1("fr_c0_rom_enable", rom_enable, 1'b0);
    tick(); #1;
    chk1("fr_c1_rom_enable", rom_enable, 1'b1);
    chk32("fr_c1_rom_address", rom_address, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
